// File: rtl/tetris_field_ctrl.sv
// Falling-piece playfield controller: holds locked background and active piece bitmaps,
// moves the piece on a divided tick with gravity, locks it, clears full rows, flags game over.
//
// state | meaning
// SPAWN | load next piece, or detect a blocked spawn
// FALL  | act on move ticks (horizontal, then down/gravity)
// LOCK  | merge piece into background
// CLEAR | examine one row per cycle, bottom to top
// OVER  | frozen until reset
module tetris_field_ctrl #(
    parameter int COLS       = 12,
    parameter int ROWS       = 12,
    parameter int TICK_DIV   = 25_000_000,
    parameter int GRAV_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 left,
    input  logic                 right,
    input  logic                 down,
    input  logic [COLS*ROWS-1:0] spawn_piece,
    output logic [COLS*ROWS-1:0] background_out,
    output logic [COLS*ROWS-1:0] piece_out,
    output logic [15:0]          lines_cleared,
    output logic                 lock_pulse,
    output logic                 busy,
    output logic                 game_over
);

    localparam int NCELL = COLS * ROWS;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;
    localparam int PW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    function automatic logic [NCELL-1:0] col_mask(input int c);
        logic [NCELL-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            m[r*COLS+c] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NCELL-1:0] COL_L = col_mask(0);
    localparam logic [NCELL-1:0] COL_R = col_mask(COLS - 1);
    localparam logic [NCELL-1:0] ROW_B = {{COLS{1'b1}}, {(NCELL-COLS){1'b0}}};

    typedef enum logic [2:0] {
        S_SPAWN,
        S_FALL,
        S_LOCK,
        S_CLEAR,
        S_OVER
    } state_t;

    state_t            state_q, state_d;
    logic [NCELL-1:0]  bg_q, bg_d;
    logic [NCELL-1:0]  piece_q, piece_d;
    logic [15:0]       lines_q, lines_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [GW-1:0]     grav_q, grav_d;

    logic              tick;
    logic              grav_pend;
    logic [NCELL-1:0]  left_sh, right_sh, down_sh;
    logic              left_ok, right_ok, down_ok;
    logic [COLS-1:0]   row_cur;
    logic              row_full;
    logic [NCELL-1:0]  cleared;
    logic              h_move;
    logic              attempt;

    assign tick      = (tick_q == TW'(TICK_DIV - 1));
    assign tick_d    = tick ? '0 : tick_q + TW'(1);
    assign grav_pend = (grav_q == GW'(GRAV_TICKS - 1));

    assign left_sh  = piece_q >> 1;
    assign right_sh = piece_q << 1;
    assign down_sh  = piece_q << COLS;

    assign left_ok  = ((piece_q & COL_L) == '0) && ((left_sh & bg_q) == '0);
    assign right_ok = ((piece_q & COL_R) == '0) && ((right_sh & bg_q) == '0);
    assign down_ok  = ((piece_q & ROW_B) == '0) && ((down_sh & bg_q) == '0);

    assign row_cur  = bg_q[int'(ptr_q)*COLS +: COLS];
    assign row_full = &row_cur;

    // Rows at and above the pointer drop by one; row 0 refills empty.
    always_comb begin
        cleared = '0;
        for (int r = 1; r < ROWS; r++) begin
            if (r > int'(ptr_q)) begin
                cleared[r*COLS +: COLS] = bg_q[r*COLS +: COLS];
            end else begin
                cleared[r*COLS +: COLS] = bg_q[(r-1)*COLS +: COLS];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bg_d    = bg_q;
        piece_d = piece_q;
        lines_d = lines_q;
        ptr_d   = ptr_q;
        grav_d  = grav_q;
        h_move  = 1'b0;
        attempt = 1'b0;
        case (state_q)
            S_SPAWN: begin
                if ((spawn_piece & bg_q) != '0) begin
                    piece_d = '0;
                    state_d = S_OVER;
                end else begin
                    piece_d = spawn_piece;
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (left && !right && left_ok) begin
                        piece_d = left_sh;
                        h_move  = 1'b1;
                    end else if (right && !left && right_ok) begin
                        piece_d = right_sh;
                        h_move  = 1'b1;
                    end
                    attempt = !h_move && (down || grav_pend);
                    if (attempt) begin
                        grav_d = '0;
                        if (down_ok) begin
                            piece_d = down_sh;
                        end else begin
                            state_d = S_LOCK;
                        end
                    end else if (!grav_pend) begin
                        grav_d = grav_q + GW'(1);
                    end
                end
            end
            S_LOCK: begin
                bg_d    = bg_q | piece_q;
                piece_d = '0;
                ptr_d   = PW'(ROWS - 1);
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (row_full) begin
                    bg_d = cleared;
                    if (lines_q != 16'hFFFF) begin
                        lines_d = lines_q + 16'd1;
                    end
                end else if (ptr_q == '0) begin
                    state_d = S_SPAWN;
                end else begin
                    ptr_d = ptr_q - PW'(1);
                end
            end
            S_OVER: begin
            end
            default: begin
                state_d = S_SPAWN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_SPAWN;
            bg_q    <= '0;
            piece_q <= '0;
            lines_q <= '0;
            ptr_q   <= '0;
            tick_q  <= '0;
            grav_q  <= '0;
        end else begin
            state_q <= state_d;
            bg_q    <= bg_d;
            piece_q <= piece_d;
            lines_q <= lines_d;
            ptr_q   <= ptr_d;
            tick_q  <= tick_d;
            grav_q  <= grav_d;
        end
    end

    assign background_out = bg_q;
    assign piece_out      = piece_q;
    assign lines_cleared  = lines_q;
    assign lock_pulse     = (state_q == S_LOCK);
    assign busy           = (state_q == S_SPAWN) || (state_q == S_LOCK) || (state_q == S_CLEAR);
    assign game_over      = (state_q == S_OVER);

endmodule

// File: doc/tetris_field_ctrl.md
# tetris_field_ctrl

Parametrised falling-piece playfield controller for the VGA Tetris game. It holds the locked background and the active piece as flat bitmaps of COLS×ROWS cells and moves the piece on a divided move tick from the left/right/down buttons, with built-in gravity. When the piece lands it is locked into the background and completed rows are cleared. It also counts cleared lines and detects game over. Its bitmap outputs feed the display renderer directly.

## Interface
- COLS, 12, playfield width in cells (≥2)
- ROWS, 12, playfield height in cells (≥2)
- TICK_DIV, 25_000_000, clk cycles per move tick (≥1)
- GRAV_TICKS, 2, move ticks per automatic down attempt (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- left  in  1  move-left request, level, sampled on move tick
- right  in  1  move-right request, level, sampled on move tick
- down  in  1  move-down request, level, sampled on move tick
- spawn_piece  in  COLS*ROWS  shape loaded at each spawn
- background_out  out  COLS*ROWS  locked cells
- piece_out  out  COLS*ROWS  active piece cells
- lines_cleared  out  16  total rows cleared, saturates at 16'hFFFF
- lock_pulse  out  1  one-cycle pulse in the LOCK cycle
- busy  out  1  high in LOCK, CLEAR and SPAWN
- game_over  out  1  sticky, cleared only by reset

Cell (r,c) is bit r*COLS+c. Row 0 is the top row and column 0 the leftmost column. Left = index−1, right = index+1, down = index+COLS.

## Operation
- States: SPAWN, FALL, LOCK, CLEAR, OVER. Reset enters SPAWN.
- Reset values: background_out=0, piece_out=0, lines_cleared=0, lock_pulse=0, game_over=0, tick and gravity counters =0, busy=1.
- SPAWN, one cycle:
  - If spawn_piece & background ≠ 0: piece←0, go to OVER.
  - Otherwise: piece←spawn_piece, go to FALL.
- FALL: only a move-tick cycle acts. Each tick runs these steps in order:
  - Horizontal: if exactly one of left/right is set and the move is legal, shift the piece. That move is the whole action for this tick. left&right together means no horizontal move.
  - Legal left: no piece bit in column 0, and the shifted piece does not overlap the background. Legal right: no bit in column COLS−1, same overlap rule. An illegal move changes nothing.
  - Down attempt: happens if no horizontal move occurred and (down is set or gravity is pending).
    - Legal down: no bit in row ROWS−1 and no overlap after the shift → shift down.
    - Illegal down → go to LOCK. The piece is unchanged on this edge.
    - Either outcome clears gravity pending and resets the gravity counter.
  - Gravity counter: increments on every FALL tick that has no down attempt. It sets pending at GRAV_TICKS−1 and holds while pending.
- LOCK, one cycle: background←background|piece; piece←0; lock_pulse=1; row pointer←ROWS−1; go to CLEAR.
- CLEAR, one cycle per row examined:
  - Row at pointer full: rows 1..pointer each take the row above them, row 0←0, lines_cleared+1 (saturating), pointer unchanged.
  - Row not full: if pointer = 0, go to SPAWN; otherwise pointer−1.
- OVER: all state frozen. Inputs are ignored until reset.

## Timing
- Tick counter runs free in every state: 0..TICK_DIV−1, tick asserted on the cycle where it reads TICK_DIV−1. Ticks outside FALL are discarded.
- Piece updates are registered: piece_out changes on the tick edge.
- Lock to new piece: 1 (LOCK) + ROWS + k (k = rows cleared) CLEAR cycles + 1 (SPAWN).
- Reset asserted in any state, including mid-CLEAR, restores all reset values on the next edge. No partial clear is retained.
- Button inputs are used as given. Debouncing and synchronisation happen upstream.

## Test plan
Unless noted: COLS=4, ROWS=4, TICK_DIV=2, GRAV_TICKS=2. No buttons pressed.
- Gravity and lock: spawn_piece=16'h0002.
  - piece_out steps 0002→0020→0200→2000, one step per 4 cycles.
  - The next gravity attempt causes lock: lock_pulse=1 and background_out=16'h2000.
  - piece_out=16'h0002 again after the CLEAR cycles plus SPAWN.
- Line clear: spawn_piece=16'h000F.
  - The piece lands at 16'hF000 and locks.
  - CLEAR empties the background: background_out=0 and lines_cleared=1.
- Edges and conflicts, with down=0:
  - spawn 16'h0001, left held → piece stays in column 0, no lock caused by the horizontal attempt.
  - spawn 16'h0002, right held → 16'h0004 on the first tick.
  - left&right held → no horizontal motion, gravity continues.
- Game over: spawn_piece=16'h0011.
  - First piece locks at 16'h1100, second at 16'h0011, giving background 16'h1111.
  - The next SPAWN sets game_over=1 with piece_out=0. Outputs stay frozen for 100 cycles.
- Reset mid-CLEAR: pulse reset during CLEAR in the line-clear case.
  - Next edge: background_out=0, lines_cleared=0, busy=1.
  - One cycle later piece_out=spawn_piece.
- Default parameters (12×12, TICK_DIV reduced to 4): a full bottom row plus one extra cell above it.
  - Clearing shifts the extra cell down by 12 bit positions.
  - lines_cleared increments by 1.
